qm_control_mc: RTL

- Registered, multi-cycle-aware successor to the combinational MIPS decode/control unit.
- Decodes opcode/funct in ID and drives the ID/EX control register.
- Sequences MULT/MULTU/DIV/DIVU through a parametrised-latency HI/LO unit and stalls decode on HI/LO hazards.
- Flags illegal instructions; supports byte/half/word loads and an EX flush.

---
 rtl/qm_control_mc_pkg.sv | 119 +++++++++++
 rtl/qm_control_mc_if.sv | 48 ++++
 rtl/qm_decode.sv | 67 ++++++
 rtl/qm_control_mc.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/qm_control_mc_pkg.sv
// Shared definitions for the multi-cycle MIPS control unit.
// Holds opcode/funct encodings, ALU codes, writeback-source and memory-size
// codes, HI/LO operation codes, the FSM state encoding and the ID/EX control
// bundle. Also provides small constructors for the common control patterns.
package qm_control_mc_pkg;

    // Major opcodes, instruction[31:26]
    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_ADDI    = 6'b001000;
    localparam logic [5:0] OP_ADDIU   = 6'b001001;
    localparam logic [5:0] OP_SLTI    = 6'b001010;
    localparam logic [5:0] OP_SLTIU   = 6'b001011;
    localparam logic [5:0] OP_ANDI    = 6'b001100;
    localparam logic [5:0] OP_ORI     = 6'b001101;
    localparam logic [5:0] OP_XORI    = 6'b001110;
    localparam logic [5:0] OP_LB      = 6'b100000;
    localparam logic [5:0] OP_LH      = 6'b100001;
    localparam logic [5:0] OP_LW      = 6'b100011;
    localparam logic [5:0] OP_LBU     = 6'b100100;
    localparam logic [5:0] OP_LHU     = 6'b100101;
    localparam logic [5:0] OP_SW      = 6'b101011;

    // SPECIAL function codes, instruction[5:0]
    localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
    localparam logic [5:0] FUNCT_MFLO  = 6'b010010;
    localparam logic [5:0] FUNCT_MULT  = 6'b011000;
    localparam logic [5:0] FUNCT_MULTU = 6'b011001;
    localparam logic [5:0] FUNCT_DIV   = 6'b011010;
    localparam logic [5:0] FUNCT_DIVU  = 6'b011011;
    localparam logic [5:0] FUNCT_ADD   = 6'b100000;
    localparam logic [5:0] FUNCT_ADDU  = 6'b100001;
    localparam logic [5:0] FUNCT_SUB   = 6'b100010;
    localparam logic [5:0] FUNCT_SUBU  = 6'b100011;
    localparam logic [5:0] FUNCT_AND   = 6'b100100;
    localparam logic [5:0] FUNCT_OR    = 6'b100101;
    localparam logic [5:0] FUNCT_XOR   = 6'b100110;
    localparam logic [5:0] FUNCT_NOR   = 6'b100111;
    localparam logic [5:0] FUNCT_SLT   = 6'b101010;

    // ALU operation codes
    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_AND   = 4'd2;
    localparam logic [3:0] ALU_OR    = 4'd3;
    localparam logic [3:0] ALU_XOR   = 4'd4;
    localparam logic [3:0] ALU_NOR   = 4'd5;
    localparam logic [3:0] ALU_SLT   = 4'd6;
    localparam logic [3:0] ALU_SLTIU = 4'd7;

    // Register writeback source
    localparam logic [1:0] WSRC_ALU = 2'd0;
    localparam logic [1:0] WSRC_MEM = 2'd1;
    localparam logic [1:0] WSRC_HI  = 2'd2;
    localparam logic [1:0] WSRC_LO  = 2'd3;

    // Memory access size
    localparam logic [1:0] MEMSZ_BYTE = 2'd0;
    localparam logic [1:0] MEMSZ_HALF = 2'd1;
    localparam logic [1:0] MEMSZ_WORD = 2'd2;

    // HI/LO unit operation; bit 1 set means a divide
    localparam logic [1:0] MULDIV_MULT  = 2'd0;
    localparam logic [1:0] MULDIV_MULTU = 2'd1;
    localparam logic [1:0] MULDIV_DIV   = 2'd2;
    localparam logic [1:0] MULDIV_DIVU  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic       reg_destination;
        logic       alu_source;
        logic [3:0] alu_control;
        logic       mem_read;
        logic       mem_write;
        logic [1:0] mem_size;
        logic       mem_signed;
        logic [1:0] reg_wsource;
        logic       reg_write;
    } ctrl_t;

    // Register-register ALU op writing RD
    function automatic ctrl_t r_ctrl(input logic [3:0] alu);
        ctrl_t c;
        c = '0;
        c.reg_destination = 1'b1;
        c.alu_control     = alu;
        c.reg_write       = 1'b1;
        return c;
    endfunction

    // Register-immediate ALU op writing RT
    function automatic ctrl_t i_ctrl(input logic [3:0] alu);
        ctrl_t c;
        c = '0;
        c.alu_source  = 1'b1;
        c.alu_control = alu;
        c.reg_write   = 1'b1;
        return c;
    endfunction

    // Load: address = base + offset, result from memory into RT
    function automatic ctrl_t ld_ctrl(input logic [1:0] size, input logic sext);
        ctrl_t c;
        c = '0;
        c.alu_source  = 1'b1;
        c.alu_control = ALU_ADD;
        c.mem_read    = 1'b1;
        c.mem_size    = size;
        c.mem_signed  = sext;
        c.reg_wsource = WSRC_MEM;
        c.reg_write   = 1'b1;
        return c;
    endfunction

endpackage

// File: rtl/qm_control_mc_if.sv
// ID-side request and EX-side control bundle of the control unit.
// Handshake: an instruction in ID (id_valid=1 with opcode/funct) is taken in
// any cycle where id_stall is 0 at the rising clock edge; while id_stall is 1
// the producer must hold id_valid, opcode and funct stable. EX outputs carry
// no back-pressure: ex_valid=1 marks a real instruction for exactly one cycle.
// fsm_state exposes the HI/LO sequencer state for observation.
// Modports: master = pipeline front end / bench, slave = control unit.
interface qm_control_mc_if;
    import qm_control_mc_pkg::*;

    logic       id_valid;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       ex_flush;
    logic       id_stall;
    logic       ex_valid;
    logic       reg_destination;
    logic       alu_source;
    logic [3:0] alu_control;
    logic       mem_read;
    logic       mem_write;
    logic [1:0] mem_size;
    logic       mem_signed;
    logic [1:0] reg_wsource;
    logic       reg_write;
    logic       muldiv_start;
    logic [1:0] muldiv_op;
    logic       hilo_write;
    logic       illegal;
    state_t     fsm_state;

    modport master (
        output id_valid, opcode, funct, ex_flush,
        input  id_stall, ex_valid, reg_destination, alu_source, alu_control,
               mem_read, mem_write, mem_size, mem_signed, reg_wsource,
               reg_write, muldiv_start, muldiv_op, hilo_write, illegal,
               fsm_state
    );

    modport slave (
        input  id_valid, opcode, funct, ex_flush,
        output id_stall, ex_valid, reg_destination, alu_source, alu_control,
               mem_read, mem_write, mem_size, mem_signed, reg_wsource,
               reg_write, muldiv_start, muldiv_op, hilo_write, illegal,
               fsm_state
    );

endinterface

// File: rtl/qm_decode.sv
// Combinational MIPS decoder.
// Ports: opcode/funct in; ctrl (control bundle), is_muldiv (MULT/MULTU/DIV/
// DIVU), is_hilo_read (MFHI/MFLO), muldiv_op and illegal out.
// Undecodable instructions produce an all-zero bundle so they never write.
module qm_decode
    import qm_control_mc_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output ctrl_t      ctrl,
    output logic       is_muldiv,
    output logic       is_hilo_read,
    output logic [1:0] muldiv_op,
    output logic       illegal
);

    always_comb begin
        ctrl         = '0;
        is_muldiv    = 1'b0;
        is_hilo_read = 1'b0;
        muldiv_op    = MULDIV_MULT;
        illegal      = 1'b0;
        case (opcode)
            OP_SPECIAL: begin
                case (funct)
                    FUNCT_ADD, FUNCT_ADDU: ctrl = r_ctrl(ALU_ADD);
                    FUNCT_SUB, FUNCT_SUBU: ctrl = r_ctrl(ALU_SUB);
                    FUNCT_AND:             ctrl = r_ctrl(ALU_AND);
                    FUNCT_OR:              ctrl = r_ctrl(ALU_OR);
                    FUNCT_XOR:             ctrl = r_ctrl(ALU_XOR);
                    FUNCT_NOR:             ctrl = r_ctrl(ALU_NOR);
                    FUNCT_SLT:             ctrl = r_ctrl(ALU_SLT);
                    FUNCT_MFHI, FUNCT_MFLO: begin
                        ctrl.reg_destination = 1'b1;
                        ctrl.reg_write       = 1'b1;
                        ctrl.reg_wsource     = (funct == FUNCT_MFHI) ? WSRC_HI : WSRC_LO;
                        is_hilo_read         = 1'b1;
                    end
                    FUNCT_MULT:  begin is_muldiv = 1'b1; muldiv_op = MULDIV_MULT;  end
                    FUNCT_MULTU: begin is_muldiv = 1'b1; muldiv_op = MULDIV_MULTU; end
                    FUNCT_DIV:   begin is_muldiv = 1'b1; muldiv_op = MULDIV_DIV;   end
                    FUNCT_DIVU:  begin is_muldiv = 1'b1; muldiv_op = MULDIV_DIVU;  end
                    default:     illegal = 1'b1;
                endcase
            end
            OP_ADDI, OP_ADDIU: ctrl = i_ctrl(ALU_ADD);
            OP_ANDI:           ctrl = i_ctrl(ALU_AND);
            OP_ORI:            ctrl = i_ctrl(ALU_OR);
            OP_XORI:           ctrl = i_ctrl(ALU_XOR);
            OP_SLTI:           ctrl = i_ctrl(ALU_SLT);
            OP_SLTIU:          ctrl = i_ctrl(ALU_SLTIU);
            OP_LB:             ctrl = ld_ctrl(MEMSZ_BYTE, 1'b1);
            OP_LH:             ctrl = ld_ctrl(MEMSZ_HALF, 1'b1);
            OP_LW:             ctrl = ld_ctrl(MEMSZ_WORD, 1'b1);
            OP_LBU:            ctrl = ld_ctrl(MEMSZ_BYTE, 1'b0);
            OP_LHU:            ctrl = ld_ctrl(MEMSZ_HALF, 1'b0);
            OP_SW: begin
                ctrl.alu_source  = 1'b1;
                ctrl.alu_control = ALU_ADD;
                ctrl.mem_write   = 1'b1;
                ctrl.mem_size    = MEMSZ_WORD;
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/qm_control_mc.sv
// Registered MIPS control unit with HI/LO multi-cycle sequencing.
// Ports: sys_clk, sys_reset_n (async, active-low); bus (slave modport) carries
// the ID request (id_valid/opcode/funct/ex_flush), the combinational id_stall,
// the registered ID/EX control bundle, muldiv_start/op, hilo_write, illegal
// and the FSM state.
// The FSM tracks the single outstanding HI/LO operation; while it is not IDLE,
// any instruction touching HI/LO is held in ID, everything else flows.
module qm_control_mc
    import qm_control_mc_pkg::*;
#(
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 32,
    parameter int CNT_W      = 6
) (
    input  logic           sys_clk,
    input  logic           sys_reset_n,
    qm_control_mc_if.slave bus
);

    localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;

    generate
        if (MUL_CYCLES < 1 || DIV_CYCLES < 1 || CNT_W < 1 || CNT_W > 30 ||
            (1 << CNT_W) <= MAX_CYCLES) begin : g_bad_params
            $error("qm_control_mc: CNT_W too small for MUL_CYCLES/DIV_CYCLES");
        end
    endgenerate

    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

    ctrl_t             dec_ctrl;
    logic              dec_muldiv;
    logic              dec_hilo_read;
    logic [1:0]        dec_op;
    logic              dec_illegal;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    ctrl_t             ex_ctrl;
    logic              ex_valid_q;
    logic              ex_illegal_q;
    logic              ex_start_q;
    logic [1:0]        ex_op_q;

    logic              id_stall;
    logic              issue;
    logic              start;
    logic              hilo_write;

    qm_decode u_decode (
        .opcode       (bus.opcode),
        .funct        (bus.funct),
        .ctrl         (dec_ctrl),
        .is_muldiv    (dec_muldiv),
        .is_hilo_read (dec_hilo_read),
        .muldiv_op    (dec_op),
        .illegal      (dec_illegal)
    );

    // DONE counts as busy so an MFHI/MFLO waits until HI/LO has been latched.
    assign id_stall = bus.id_valid & (state_q != ST_IDLE) & (dec_muldiv | dec_hilo_read);
    // A flushed instruction is still consumed from ID but becomes a bubble.
    assign issue    = bus.id_valid & ~id_stall & ~bus.ex_flush;
    assign start    = issue & dec_muldiv;

    // ID/EX register
    always_ff @(posedge sys_clk or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            ex_ctrl      <= '0;
            ex_valid_q   <= 1'b0;
            ex_illegal_q <= 1'b0;
            ex_start_q   <= 1'b0;
            ex_op_q      <= MULDIV_MULT;
        end else begin
            ex_ctrl      <= issue ? dec_ctrl : '0;
            ex_valid_q   <= issue;
            ex_illegal_q <= issue & dec_illegal;
            ex_start_q   <= start;
            if (start) begin
                ex_op_q <= dec_op;
            end
        end
    end

    // FSM state register
    always_ff @(posedge sys_clk or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // FSM next state. The counter holds the cycles still to go before DONE;
    // DONE lands exactly latency cycles after the accept edge, and a latency
    // of 1 skips BUSY entirely. In BUSY the counter is never 0, so it cannot wrap.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    cnt_d   = dec_op[1] ? DIV_LOAD : MUL_LOAD;
                    state_d = (cnt_d == '0) ? ST_DONE : ST_BUSY;
                end
            end
            ST_BUSY: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // FSM outputs
    always_comb begin
        hilo_write = (state_q == ST_DONE);
    end

    assign bus.id_stall        = id_stall;
    assign bus.ex_valid        = ex_valid_q;
    assign bus.reg_destination = ex_ctrl.reg_destination;
    assign bus.alu_source      = ex_ctrl.alu_source;
    assign bus.alu_control     = ex_ctrl.alu_control;
    assign bus.mem_read        = ex_ctrl.mem_read;
    assign bus.mem_write       = ex_ctrl.mem_write;
    assign bus.mem_size        = ex_ctrl.mem_size;
    assign bus.mem_signed      = ex_ctrl.mem_signed;
    assign bus.reg_wsource     = ex_ctrl.reg_wsource;
    assign bus.reg_write       = ex_ctrl.reg_write;
    assign bus.muldiv_start    = ex_start_q;
    assign bus.muldiv_op       = ex_op_q;
    assign bus.hilo_write      = hilo_write;
    assign bus.illegal         = ex_illegal_q;
    assign bus.fsm_state       = state_q;

endmodule
